hrange_stepped: RTL
===================

# hrange_stepped

Parametrised range generator with a ready/valid output handshake. It emits the sequence `base, base+step, base+2*step, …` until the value passes `limit`. Compared with the fixed 32-bit range generator it adds:
- configurable data width,
- negative-step (descending) ranges,
- a zero-step guard and wrap-free arithmetic,
- per-value repetition,
- a beat ordinal and a last-beat flag.

It sits as a leaf generator instance inside generated consumer modules, which drive its `_start`/`_ready` and sample `_valid`/`_done`.

## Interface
Parameters:
- `WIDTH`, 32 — signed width of `base`, `limit`, `step`, `_out0`, `_out1`.
- `REPEAT`, 1 — number of consecutive beats emitted per sequence value; must be ≥1.

Ports:
- `_clock` input 1 — single clock; all logic on the rising edge.
- `_reset` input 1 — synchronous, active-high reset.
- `base` input WIDTH signed — first value; sampled only on the `_start` cycle.
- `limit` input WIDTH signed — exclusive bound; sampled only on the `_start` cycle.
- `step` input WIDTH signed — increment, may be negative; sampled only on the `_start` cycle.
- `_start` input 1 — capture the inputs and begin a new sequence.
- `_ready` input 1 — consumer accepts the current beat.
- `_valid` output 1 — `_out0`, `_out1` and `_last` hold a valid beat.
- `_done` output 1 — generator idle/finished.
- `_out0` output WIDTH signed — current sequence value.
- `_out1` output WIDTH — ordinal of the current value (0-based, counts distinct values, not repeats).
- `_last` output 1 — high on the final beat of the sequence.

## Operation
- States: `S_DONE`, `S_EMIT`.
- Reset takes precedence over `_start` in the same cycle.
- Reset values: state `S_DONE`; `_valid`=0, `_done`=1, `_last`=0, `_out0`=0, `_out1`=0; internal value, ordinal and repeat counter are 0.
- Continue condition:
  - `step`>0: continue while value < `limit`.
  - `step`<0: continue while value > `limit`.
  - `step`=0: the range is empty.
- `_start` (from any state) registers `base`, `limit`, `step`; the ordinal and repeat counter are cleared.
  - If the range is non-empty (continue condition true for `base`): go to `S_EMIT` with `_out0`=`base`, `_out1`=0, `_valid`=1, `_done`=0.
  - Otherwise: go to `S_DONE` with `_valid`=0, `_done`=1.
- `_start` during `S_EMIT` abandons the current sequence without completing the pending beat.
- `S_EMIT`: the beat is held stable while `_valid`=1 and `_ready`=0.
- On a transfer (`_valid` && `_ready` at the edge):
  - If the repeat counter < `REPEAT`-1: increment it; re-emit the same `_out0`/`_out1`.
  - Otherwise: clear the repeat counter; compute next = value + `step`.
    - If next satisfies the continue condition: emit next, with `_out1`+1.
    - Otherwise: `_valid`=0, `_done`=1, go to `S_DONE`.
- Arithmetic:
  - next is computed in WIDTH+1 bits from sign-extended operands, and the comparison uses the WIDTH+1-bit result. Overflow past the signed WIDTH range therefore always terminates and never wraps.
  - `_out1` wraps modulo 2^WIDTH.
- `_last` is combinationally consistent with the beat: high exactly when the repeat counter = `REPEAT`-1 and the next value would fail the continue condition. It is registered alongside `_out0`.
- `S_DONE`: `_done` held at 1; `_valid`=0; `_ready` ignored; outputs keep their last values.

## Timing
- `_start` at edge t:
  - non-empty range: first beat visible after edge t (`_valid`=1 in cycle t+1);
  - empty range: `_done`=1 in cycle t+1 and `_valid` is never asserted.
- Throughput is one beat per cycle while `_ready`=1; `_valid` stays high between beats with no bubble.
- The final transfer at edge t gives `_valid`=0 and `_done`=1 in cycle t+1.
- `_reset` at edge t gives `_valid`=0 and `_done`=1 in cycle t+1, regardless of state or `_start`.
- `_ready` is registered nowhere; the block has no combinational path from `_ready` to any output.

## Test plan
- WIDTH=32, REPEAT=1, (1,11,3), `_ready`=1 → beats `_out0` 1,4,7,10 with `_out1` 0..3; `_last` on 10; `_done`=1 the cycle after beat 10.
- (0,10,2) with `_ready` toggling 1,0,0,1… → values 0,2,4,6,8 each held stable across stall cycles; no beat lost or duplicated.
- (10,0,-3) → 10,7,4,1 then done. (5,5,1) → no `_valid`, `_done` the cycle after `_start`. (0,10,0) → same empty behaviour.
- WIDTH=8, (100,127,20) → 100,120 then done. The next value 140 does not wrap to -116, and `_last` is on 120.
- REPEAT=2, (0,3,1) → `_out0` 0,0,1,1,2,2 with `_out1` 0,0,1,1,2,2; `_last` only on the second 2.
- `_reset` asserted mid-sequence (after value 4 of (0,10,2)) together with `_start` → next cycle `_valid`=0, `_done`=1. A later `_start` (1,11,3) restarts cleanly at 1.

Source files
------------

// File: rtl/hrange_stepped.sv
// hrange_stepped: signed stepped range generator with per-value repeat and a ready/valid output.
module hrange_stepped #(
  parameter int WIDTH  = 32,
  parameter int REPEAT = 1
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _start,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _out0,
  output logic        [WIDTH-1:0] _out1,
  output logic                    _last
);
  localparam int RW = $clog2(REPEAT + 1);
  typedef enum logic {S_DONE, S_EMIT} state_t;
  typedef logic signed [WIDTH:0] wide_t;
  function automatic wide_t add(input logic signed [WIDTH-1:0] v, input logic signed [WIDTH-1:0] s);
    return {v[WIDTH-1], v} + {s[WIDTH-1], s};
  endfunction
  // One extra bit keeps an overflowing next value out of range instead of wrapping.
  function automatic logic go(input wide_t v, input logic signed [WIDTH-1:0] l, input logic signed [WIDTH-1:0] s);
    wide_t lw;
    lw = {l[WIDTH-1], l};
    return s[WIDTH-1] ? (v > lw) : (|s ? (v < lw) : 1'b0);
  endfunction
  state_t                  state_q;
  logic signed [WIDTH-1:0] val_q, lim_q, step_q, val_d;
  logic        [WIDTH-1:0] ord_q;
  logic        [RW-1:0]    rep_q;
  logic                    valid_q, done_q, last_q;
  logic                    nxt_go, nxt_fin, cur_fin, base_go, base_fin, rep_end;
  wide_t                   nxt_w;
  always_comb begin
    nxt_w    = add(val_q, step_q);
    val_d    = nxt_w[WIDTH-1:0];
    nxt_go   = go(nxt_w, lim_q, step_q);
    cur_fin  = !nxt_go;
    nxt_fin  = !go(add(val_d, step_q), lim_q, step_q);
    base_go  = go({base[WIDTH-1], base}, limit, step);
    base_fin = !go(add(base, step), limit, step);
    rep_end  = rep_q == RW'(REPEAT - 1);
  end
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= S_DONE;
      val_q   <= '0;
      lim_q   <= '0;
      step_q  <= '0;
      ord_q   <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
      last_q  <= 1'b0;
    end else if (_start) begin
      lim_q   <= limit;
      step_q  <= step;
      val_q   <= base;
      ord_q   <= '0;
      rep_q   <= '0;
      valid_q <= base_go;
      done_q  <= !base_go;
      state_q <= base_go ? S_EMIT : S_DONE;
      last_q  <= base_go && REPEAT == 1 && base_fin;
    end else if (state_q == S_EMIT && _ready) begin
      if (!rep_end) begin
        rep_q  <= rep_q + RW'(1);
        last_q <= (rep_q + RW'(1) == RW'(REPEAT - 1)) && cur_fin;
      end else begin
        rep_q <= '0;
        if (nxt_go) begin
          val_q  <= val_d;
          ord_q  <= ord_q + 1'b1;
          last_q <= REPEAT == 1 && nxt_fin;
        end else begin
          state_q <= S_DONE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end
  assign _valid = valid_q;
  assign _done  = done_q;
  assign _out0  = val_q;
  assign _out1  = ord_q;
  assign _last  = last_q;
endmodule
